// File: rtl/spi_wb_master_burst_if.sv
// Byte-stream and Wishbone signal bundle for the SPI burst bridge.
// The master side is the bridge; the slave side is the byte source plus bus slave.
interface spi_wb_master_burst_if #(
    parameter int ADDR_BYTES = 1,
    parameter int DATA_BYTES = 4
);
    logic [7:0]              rx_data;
    logic                    rx_stb;
    logic [7:0]              tx_data;
    logic                    tx_stb;
    logic                    wb_cyc;
    logic                    wb_stb;
    logic                    wb_we;
    logic [8*ADDR_BYTES-1:0] wb_adr;
    logic [8*DATA_BYTES-1:0] wb_dat_o;
    logic [DATA_BYTES-1:0]   wb_sel;
    logic [8*DATA_BYTES-1:0] wb_dat_i;
    logic                    wb_ack;
    logic                    wb_err;

    modport master (
        input  rx_data, rx_stb, wb_dat_i, wb_ack, wb_err,
        output tx_data, tx_stb, wb_cyc, wb_stb, wb_we,
        output wb_adr, wb_dat_o, wb_sel
    );

    modport slave (
        output rx_data, rx_stb, wb_dat_i, wb_ack, wb_err,
        input  tx_data, tx_stb, wb_cyc, wb_stb, wb_we,
        input  wb_adr, wb_dat_o, wb_sel
    );
endinterface

// File: rtl/spi_wb_master_burst.sv
// SPI byte-stream to Wishbone master with burst transfers, address
// auto-increment, bus-error reporting and slave timeout.
module spi_wb_master_burst #(
    parameter int ADDR_BYTES = 1,
    parameter int DATA_BYTES = 4,
    parameter int TIMEOUT    = 255
) (
    input logic clk,
    input logic rst,
    spi_wb_master_burst_if.master bus
);
    localparam int AW = 8*ADDR_BYTES;
    localparam int DW = 8*DATA_BYTES;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT-1);
    localparam logic [7:0]  A_LAST   = 8'(ADDR_BYTES-1);
    localparam logic [7:0]  D_LAST   = 8'(DATA_BYTES-1);

    typedef enum logic [2:0] {
        IDLE, ADDR, WDATA, RWAIT, WWAIT, RDATA
    } state_t;

    state_t        state;
    logic [7:0]    tx_data;
    logic          tx_stb;
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_o;
    logic [DW-1:0] rd_sh;
    logic [3:0]    words;
    logic [7:0]    byte_cnt;
    logic [15:0]   tmo_cnt;
    logic          done;
    logic          err_q;

    logic tmo_hit;
    logic term;
    logic hit;
    logic hit_ok;
    logic fin;
    logic fin_ok;

    assign tmo_hit = tmo_cnt == TMO_LAST;
    assign term    = bus.wb_ack | bus.wb_err | tmo_hit;
    assign hit     = cyc & term;
    assign hit_ok  = cyc & bus.wb_ack & ~bus.wb_err;
    // A byte arriving on the termination cycle already sees the status.
    assign fin     = done | hit;
    assign fin_ok  = done ? ~err_q : hit_ok;

    assign bus.tx_data  = tx_data;
    assign bus.tx_stb   = tx_stb;
    assign bus.wb_cyc   = cyc;
    assign bus.wb_stb   = stb;
    assign bus.wb_we    = we;
    assign bus.wb_adr   = adr;
    assign bus.wb_dat_o = dat_o;
    assign bus.wb_sel   = '1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tx_data  <= 8'h00;
            tx_stb   <= 1'b0;
            cyc      <= 1'b0;
            stb      <= 1'b0;
            we       <= 1'b0;
            adr      <= '0;
            dat_o    <= '0;
            rd_sh    <= '0;
            words    <= 4'd0;
            byte_cnt <= 8'd0;
            tmo_cnt  <= 16'd0;
            done     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            tx_stb <= bus.rx_stb;

            // Bus side runs independently of the byte strobe.
            if (cyc) begin
                tmo_cnt <= tmo_cnt + 16'd1;
                if (term) begin
                    cyc   <= 1'b0;
                    stb   <= 1'b0;
                    done  <= 1'b1;
                    err_q <= ~hit_ok;
                    if (state == RWAIT && hit_ok)
                        rd_sh <= bus.wb_dat_i;
                end
            end

            if (bus.rx_stb) begin
                tx_data <= 8'h00;
                unique case (state)
                    IDLE: begin
                        if (bus.rx_data != 8'h00) begin
                            we       <= bus.rx_data[7];
                            words    <= bus.rx_data[3:0];
                            byte_cnt <= 8'd0;
                            state    <= ADDR;
                        end
                    end
                    ADDR: begin
                        adr <= AW'({adr, bus.rx_data});
                        if (byte_cnt == A_LAST) begin
                            byte_cnt <= 8'd0;
                            if (we) begin
                                state <= WDATA;
                            end else begin
                                cyc     <= 1'b1;
                                stb     <= 1'b1;
                                done    <= 1'b0;
                                err_q   <= 1'b0;
                                tmo_cnt <= 16'd0;
                                state   <= RWAIT;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end
                    WDATA: begin
                        dat_o <= DW'({dat_o, bus.rx_data});
                        if (byte_cnt == D_LAST) begin
                            byte_cnt <= 8'd0;
                            cyc      <= 1'b1;
                            stb      <= 1'b1;
                            done     <= 1'b0;
                            err_q    <= 1'b0;
                            tmo_cnt  <= 16'd0;
                            state    <= WWAIT;
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end
                    RWAIT, WWAIT: begin
                        if (fin) begin
                            tx_data  <= fin_ok ? 8'h55 : 8'hEE;
                            done     <= 1'b0;
                            byte_cnt <= 8'd0;
                            if (!fin_ok) begin
                                state <= IDLE;
                            end else if (state == RWAIT) begin
                                state <= RDATA;
                            end else if (words == 4'd0) begin
                                state <= IDLE;
                            end else begin
                                adr   <= adr + AW'(1);
                                words <= words - 4'd1;
                                state <= WDATA;
                            end
                        end
                    end
                    RDATA: begin
                        tx_data <= rd_sh[DW-1 -: 8];
                        rd_sh   <= rd_sh << 8;
                        if (byte_cnt == D_LAST) begin
                            byte_cnt <= 8'd0;
                            if (words == 4'd0) begin
                                state <= IDLE;
                            end else begin
                                adr     <= adr + AW'(1);
                                words   <= words - 4'd1;
                                cyc     <= 1'b1;
                                stb     <= 1'b1;
                                done    <= 1'b0;
                                err_q   <= 1'b0;
                                tmo_cnt <= 16'd0;
                                state   <= RWAIT;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/spi_wb_master_burst.md
Name: spi_wb_master_burst

Overview:
- Byte-stream to Wishbone master bridge; successor of the single-word SPI command state machine.
- Sits between the SPI byte deserialiser (rx_data/rx_stb, tx_data/tx_stb) and a classic Wishbone bus.
- Adds parametrised address and data width, burst transfers with address auto-increment, bus-error reporting and a slave timeout.

Parameters:
ADDR_BYTES, 1, address bytes sent per command, MSB first; address width AW = 8*ADDR_BYTES
DATA_BYTES, 4, bytes per bus word, MSB first; data width DW = 8*DATA_BYTES
TIMEOUT, 255, clk cycles a bus cycle may wait for ack/err before it is aborted (1..65535)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
rx_data  in  8  received byte
rx_stb  in  1  one-cycle pulse, rx_data valid
tx_data  out  8  byte to transmit; valid with tx_stb
tx_stb  out  1  one-cycle pulse, one per rx_stb
wb_cyc  out  1  bus cycle
wb_stb  out  1  strobe
wb_we  out  1  write enable
wb_adr  out  AW  word address
wb_dat_o  out  DW  write data
wb_sel  out  DATA_BYTES  byte selects, always all ones
wb_dat_i  in  DW  read data
wb_ack  in  1  normal termination
wb_err  in  1  error termination

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. tx_data=0x00, tx_stb=0, wb_cyc=0, wb_stb=0, wb_we=0, wb_adr=0, wb_dat_o=0. Word counter, byte counter and timeout counter are 0. Reset mid-transaction abandons the bus cycle immediately.
- Byte stream:
  - tx_stb is rx_stb delayed by exactly 1 cycle.
  - tx_data is updated only on rx_stb cycles and holds between strobes.
- Command byte: bit7 = W (write), bits3:0 = N-1. Burst length N is 1..16 words. Bits6:4 are ignored. Byte 0x00 in IDLE is ignored: stay in IDLE, tx 0x00.
- IDLE: on a nonzero rx byte, latch W and N and go to ADDR. tx 0x00.
- ADDR: shift in ADDR_BYTES bytes, MSB first, into wb_adr. tx 0x00 for each. After the last byte:
  - W=1: go to WDATA.
  - W=0: assert cyc/stb with we=0, go to RWAIT.
- WDATA: shift DATA_BYTES bytes, MSB first, into wb_dat_o. tx 0x00. After the last byte, assert cyc/stb with we=1 and go to WWAIT.
- RWAIT / WWAIT (bus cycle pending): each rx byte gets tx 0x00 until the bus cycle has terminated.
  - The first rx byte after termination gets a status byte: 0x55 = ack, 0xEE = err or timeout.
  - The bus cycle ends on the cycle wb_ack or wb_err is sampled high: cyc/stb drop on the next edge. On ack in RWAIT, wb_dat_i is latched into the read shift register.
  - If rx_stb coincides with the ack/err cycle, that byte already reports the status byte.
  - After 0x55:
    - Read: go to RDATA.
    - Write, more words left: increment wb_adr by 1 (wraps modulo 2^AW), decrement the word counter, go to WDATA.
    - Write, last word: go to IDLE.
  - After 0xEE: abort the rest of the burst and go to IDLE.
- RDATA: the next DATA_BYTES rx bytes get the read word, MSB first. After the last byte:
  - More words left: increment wb_adr and immediately start the next read cycle (RWAIT).
  - Last word: go to IDLE.
- Timeout: the counter clears when cyc rises and counts while cyc=1. When it reaches TIMEOUT with no ack/err, drop cyc/stb and flag error, so the status byte is 0xEE. An ack/err arriving on the same cycle as the timeout wins (normal termination).
- wb_ack or wb_err asserted while cyc=0 is ignored.
- rx_stb only moves the byte state machine. Bus termination and the timeout advance independently of rx_stb.
- wb_we is stable for the whole command. wb_adr and wb_dat_o are stable while cyc=1.

Test Plan:
1. Single write, ADDR_BYTES=2, DATA_BYTES=4. rx 0x80,0x12,0x34,0xDE,0xAD,0xBE,0xEF; slave acks after 3 cycles; then rx 0x00,0x00 → one cycle with adr=0x1234, dat_o=0xDEADBEEF, we=1, sel=0xF. tx: seven 0x00 bytes, then 0x55 (if ack already seen), then 0x00, back in IDLE.
2. Read burst N=2. rx 0x01,0x00,0x10, then dummy bytes; slave returns 0x11223344 at adr 0x0010 and 0xA5A5A5A5 at adr 0x0011 → tx, after any 0x00 wait bytes: 0x55,11,22,33,44, [0x00 wait bytes],0x55,A5,A5,A5,A5. adr increments exactly once.
3. Bus error. Read where the slave asserts wb_err → status 0xEE, no data bytes follow. The next rx byte 0x00 is treated in IDLE and tx is 0x00.
4. Timeout, TIMEOUT=8, slave never responds → cyc drops 8 cycles after rising. Next rx byte gets 0xEE, burst aborted, state IDLE.
5. Write burst wrap: ADDR_BYTES=1, adr=0xFF, N=2 → second cycle uses adr=0x00.
6. Reset mid-burst: rst=0 while cyc=1 → cyc/stb/tx_stb drop at once. After release, rx 0x00 gets tx 0x00, and a fresh command executes normally.
